fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Program-counter sequencer for the 9-bit instruction ROM.
- Drives the ROM address (prog_ctr) and qualifies each fetched word with fetch_valid.
- Applies sequential increment, LUT-indexed absolute jumps and signed relative branches, plus stall and halt control from the decoder.
- Owns a small writable branch-target LUT so absolute targets fit inside 9-bit instructions.

Parameters:
- D, 10, ROM address width; PC range 0..2**D-1.
- LW, 4, LUT index width; 2**LW target entries.
- OW, 8, width of the signed relative offset.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin execution from address 0 (honoured in IDLE and HALT only).
- stall  in  1  freeze PC and all control this cycle.
- halt_req  in  1  current instruction is halt.
- branch_taken  in  1  current instruction redirects the PC.
- jump_abs  in  1  with branch_taken: 1 = LUT target, 0 = relative.
- target_idx  in  LW  LUT index for an absolute jump.
- rel_off  in  OW  signed two's-complement PC offset.
- lut_we  in  1  LUT write enable.
- lut_waddr  in  LW  LUT write index.
- lut_wdata  in  D  LUT write data.
- prog_ctr  out  D  ROM address.
- fetch_valid  out  1  the mach_code at prog_ctr is to be executed this cycle.
- busy  out  1  FSM in RUN.
- done  out  1  FSM in HALT, sticky until start or reset.

Behaviour:
- Reset (async, any state):
  - FSM=IDLE, prog_ctr=0, fetch_valid=0, busy=0, done=0.
  - All LUT entries = 0.
- FSM states: IDLE, RUN, HALT.
- IDLE:
  - prog_ctr holds 0 and fetch_valid=0.
  - start=1 -> RUN next cycle with prog_ctr=0.
- RUN:
  - busy=1 and fetch_valid = ~stall (combinational).
  - Next-PC priority, evaluated each rising edge:
    1. stall=1: prog_ctr and state held; halt_req, branch_taken and start ignored.
    2. halt_req=1: go to HALT; prog_ctr held at the halt instruction address.
    3. branch_taken=1 and jump_abs=1: prog_ctr <= lut[target_idx].
    4. branch_taken=1 and jump_abs=0: prog_ctr <= prog_ctr + sign_extend(rel_off), truncated to D bits (mod 2**D).
    5. Otherwise: prog_ctr <= prog_ctr + 1, mod 2**D (2**D-1 wraps to 0).
  - start is ignored in RUN.
- HALT:
  - done=1, busy=0, fetch_valid=0, prog_ctr held.
  - start=1 -> RUN with prog_ctr=0; done clears on that same edge.
- Latency:
  - Redirect takes effect on the edge after the instruction is presented.
  - No delay slot.
  - The target is fetched in the following cycle with fetch_valid=1 (unless stalled).
- LUT:
  - 2**LW x D registers.
  - Synchronous write when lut_we=1, in any state, and unaffected by stall.
  - Read is combinational.
  - A write and a jump reading the same index in the same cycle: the jump uses the old value; the new value is visible from the next cycle.
- Control inputs are don't-care outside RUN, except start, lut_we, lut_waddr and lut_wdata.
- Reset asserted mid-RUN: immediate return to IDLE, all outputs per reset, LUT cleared.

Test Plan:
- Reset then start with no control inputs for 5 cycles -> prog_ctr 0,1,2,3,4 with fetch_valid=1 and busy=1; IDLE before start shows prog_ctr=0, fetch_valid=0.
- Write lut[3]=10'h155, run to pc=7, branch_taken=1, jump_abs=1, target_idx=3 -> next prog_ctr=0x155, then 0x156; same-cycle write lut[3]=0x020 with jump to idx 3 -> 0x155, a later jump -> 0x020.
- Relative branches:
  - At pc=20: rel_off=-5 -> 15; rel_off=+127 -> 147.
  - At pc=2: rel_off=-4 -> 1022 (wrap).
  - At pc=1023 with no branch: increments to 0.
- At pc=9, stall=1 for 3 cycles together with halt_req=1 and branch_taken=1 -> prog_ctr stays 9, fetch_valid=0; stall drops with halt_req=1 -> HALT, done=1, prog_ctr=9.
- In HALT: start=1 -> RUN, prog_ctr=0, done=0 on that edge. In RUN: start=1 alone -> plain increment.
- Reset pulsed asynchronously mid-RUN at pc=50 after LUT writes -> prog_ctr=0, busy=0 without a clock edge; all LUT entries read 0 afterwards.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer for the instruction ROM: sequential fetch, LUT-indexed
// absolute jumps, signed relative branches, stall and halt control.
module fetch_ctrl #(
  parameter int unsigned D  = 10,
  parameter int unsigned LW = 4,
  parameter int unsigned OW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          branch_taken,
  input  logic          jump_abs,
  input  logic [LW-1:0] target_idx,
  input  logic [OW-1:0] rel_off,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  output logic [D-1:0]  prog_ctr,
  output logic          fetch_valid,
  output logic          busy,
  output logic          done
);

  localparam int NLUT = 1 << LW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] lut_q [NLUT];
  logic [D-1:0] rel_ext;

  // Offset is two's complement; the signed cast sign-extends to the PC width.
  assign rel_ext = D'($signed(rel_off));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Branch-target table; a same-cycle jump to the written index sees the old entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NLUT; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_we) begin
      lut_q[lut_waddr] <= lut_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (halt_req) begin
            state_d = S_HALT;
          end else if (branch_taken && jump_abs) begin
            pc_d = lut_q[target_idx];
          end else if (branch_taken) begin
            pc_d = pc_q + rel_ext;
          end else begin
            pc_d = pc_q + D'(1);
          end
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  assign prog_ctr    = pc_q;
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_HALT);
  assign fetch_valid = busy & ~stall;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequencing, LUT jumps, relative branches, stall/halt, async reset.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stall, halt_req, branch_taken, jump_abs;
  logic [3:0] target_idx;
  logic [7:0] rel_off;
  logic       lut_we;
  logic [3:0] lut_waddr;
  logic [9:0] lut_wdata;
  logic [9:0] prog_ctr;
  logic       fetch_valid, busy, done;

  int passed = 0;
  int total  = 0;

  fetch_ctrl #(.D(10), .LW(4), .OW(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .halt_req(halt_req),
    .branch_taken(branch_taken), .jump_abs(jump_abs), .target_idx(target_idx),
    .rel_off(rel_off), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .prog_ctr(prog_ctr), .fetch_valid(fetch_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    start = 0; stall = 0; halt_req = 0; branch_taken = 0; jump_abs = 0;
    target_idx = 0; rel_off = 0; lut_we = 0; lut_waddr = 0; lut_wdata = 0;
  endtask

  task automatic run_to(input logic [9:0] tgt);
    int n = 0;
    while (prog_ctr !== tgt && n < 2000) begin
      tick();
      n++;
    end
    total++;
    if (prog_ctr !== tgt) $display("FAIL run_to: prog_ctr=%0d required=%0d (cycle budget)", prog_ctr, tgt);
    else passed++;
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset = 1;
    #2;
    total++; if (prog_ctr !== 10'd0) $display("FAIL reset_pc: got %0d want 0", prog_ctr); else passed++;
    total++; if ({fetch_valid, busy, done} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {fetch_valid, busy, done}); else passed++;
    tick();
    reset = 0;
    tick();
    total++; if (prog_ctr !== 10'd0 || fetch_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle: pc=%0d fv=%b busy=%b want 0/0/0", prog_ctr, fetch_valid, busy); else passed++;
  endtask

  task automatic test_sequential();
    start = 1;
    tick();
    start = 0;
    total++; if (prog_ctr !== 10'd0 || busy !== 1'b1 || fetch_valid !== 1'b1) $display("FAIL start: pc=%0d busy=%b fv=%b want 0/1/1", prog_ctr, busy, fetch_valid); else passed++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++; if (prog_ctr !== 10'(i) || fetch_valid !== 1'b1 || busy !== 1'b1) $display("FAIL seq_%0d: pc=%0d fv=%b busy=%b want %0d/1/1", i, prog_ctr, fetch_valid, busy, i); else passed++;
    end
  endtask

  task automatic test_abs_jump();
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h155;
    tick();
    lut_we = 0;
    run_to(10'd7);
    branch_taken = 1; jump_abs = 1; target_idx = 4'd3;
    tick();
    branch_taken = 0; jump_abs = 0;
    total++; if (prog_ctr !== 10'h155) $display("FAIL abs_jump: got %h want 155", prog_ctr); else passed++;
    tick();
    total++; if (prog_ctr !== 10'h156) $display("FAIL abs_next: got %h want 156", prog_ctr); else passed++;
    branch_taken = 1; jump_abs = 1; target_idx = 4'd3;
    lut_we = 1; lut_waddr = 4'd3; lut_wdata = 10'h020;
    tick();
    branch_taken = 0; jump_abs = 0; lut_we = 0;
    total++; if (prog_ctr !== 10'h155) $display("FAIL abs_old_value: got %h want 155", prog_ctr); else passed++;
    tick();
    total++; if (prog_ctr !== 10'h156) $display("FAIL abs_after_wr: got %h want 156", prog_ctr); else passed++;
    branch_taken = 1; jump_abs = 1; target_idx = 4'd3;
    tick();
    branch_taken = 0; jump_abs = 0;
    total++; if (prog_ctr !== 10'h020 || fetch_valid !== 1'b1) $display("FAIL abs_new_value: pc=%h fv=%b want 020/1", prog_ctr, fetch_valid); else passed++;
  endtask

  task automatic test_relative();
    logic [7:0] offs [6];
    logic [9:0] want [6];
    offs = '{8'hF4, 8'hFB, 8'h05, 8'h7F, 8'h00, 8'h00};
    want = '{10'd20, 10'd15, 10'd20, 10'd147, 10'd0, 10'd0};
    for (int i = 0; i < 4; i++) begin
      branch_taken = 1; jump_abs = 0; rel_off = offs[i];
      tick();
      branch_taken = 0;
      total++; if (prog_ctr !== want[i]) $display("FAIL rel_%0d: got %0d want %0d", i, prog_ctr, want[i]); else passed++;
    end
    branch_taken = 1; jump_abs = 1; target_idx = 4'd0;
    tick();
    branch_taken = 0; jump_abs = 0;
    total++; if (prog_ctr !== 10'd0) $display("FAIL lut_zero: got %0d want 0", prog_ctr); else passed++;
    tick(); tick();
    branch_taken = 1; rel_off = 8'hFC;
    tick();
    branch_taken = 0;
    total++; if (prog_ctr !== 10'd1022) $display("FAIL rel_wrap: got %0d want 1022", prog_ctr); else passed++;
    tick();
    total++; if (prog_ctr !== 10'd1023) $display("FAIL inc_1023: got %0d want 1023", prog_ctr); else passed++;
    tick();
    total++; if (prog_ctr !== 10'd0) $display("FAIL inc_wrap: got %0d want 0", prog_ctr); else passed++;
  endtask

  task automatic test_stall_halt();
    run_to(10'd9);
    stall = 1; halt_req = 1; branch_taken = 1; rel_off = 8'h05; start = 1;
    #1;
    total++; if (fetch_valid !== 1'b0) $display("FAIL stall_fv: got %b want 0", fetch_valid); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (prog_ctr !== 10'd9 || fetch_valid !== 1'b0 || busy !== 1'b1) $display("FAIL stall_%0d: pc=%0d fv=%b busy=%b want 9/0/1", i, prog_ctr, fetch_valid, busy); else passed++;
    end
    stall = 0; branch_taken = 0; start = 0;
    #1;
    total++; if (fetch_valid !== 1'b1) $display("FAIL unstall_fv: got %b want 1", fetch_valid); else passed++;
    tick();
    halt_req = 0;
    total++; if (prog_ctr !== 10'd9 || done !== 1'b1 || busy !== 1'b0 || fetch_valid !== 1'b0) $display("FAIL halt: pc=%0d done=%b busy=%b fv=%b want 9/1/0/0", prog_ctr, done, busy, fetch_valid); else passed++;
    tick();
    total++; if (prog_ctr !== 10'd9 || done !== 1'b1) $display("FAIL halt_hold: pc=%0d done=%b want 9/1", prog_ctr, done); else passed++;
  endtask

  task automatic test_restart();
    start = 1;
    tick();
    total++; if (prog_ctr !== 10'd0 || done !== 1'b0 || busy !== 1'b1) $display("FAIL restart: pc=%0d done=%b busy=%b want 0/0/1", prog_ctr, done, busy); else passed++;
    tick();
    start = 0;
    total++; if (prog_ctr !== 10'd1) $display("FAIL start_in_run: got %0d want 1", prog_ctr); else passed++;
  endtask

  task automatic test_async_reset();
    lut_we = 1; lut_waddr = 4'd2; lut_wdata = 10'h3FF;
    tick();
    lut_waddr = 4'd9; lut_wdata = 10'h111;
    tick();
    lut_we = 0;
    run_to(10'd50);
    #2;
    reset = 1;
    #1;
    total++; if (prog_ctr !== 10'd0 || busy !== 1'b0 || fetch_valid !== 1'b0 || done !== 1'b0) $display("FAIL async_reset: pc=%0d busy=%b fv=%b done=%b want 0/0/0/0", prog_ctr, busy, fetch_valid, done); else passed++;
    tick();
    reset = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 16; i++) begin
      branch_taken = 1; jump_abs = 1; target_idx = 4'(i);
      tick();
      total++; if (prog_ctr !== 10'd0) $display("FAIL lut_cleared_%0d: got %0d want 0", i, prog_ctr); else passed++;
    end
    branch_taken = 0; jump_abs = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_abs_jump();
    test_relative();
    test_stall_halt();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
